// File: rtl/instr_fetch_unit.sv
// Purpose: holds the fetch PC, issues in-order imem requests and buffers responses for decode; redirects flush.
// Latency: a response sampled at edge N is on out_* right after edge N (registered FIFO, no bypass).
// Backpressure: out_ready low fills the FIFO; request issue is credit-limited so responses never stall.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2
) (
  input  logic        clock,
  input  logic        start,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(MAX_OUT + 1);
  localparam int SW = ((CW > IW) ? CW : IW) + 1;

  logic [31:0]   pc;
  logic [31:0]   rsp_pc;
  logic [IW-1:0] inflight;
  logic [IW-1:0] drop;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];

  logic [SW-1:0] credit_used;
  logic          fire;
  logic          pop;
  logic          push;

  // Credit accounting: FIFO slots already claimed by buffered words plus
  // requests whose responses will be kept. Issue only while a slot is free,
  // so a response can always be accepted without stalling memory.
  always_comb begin
    credit_used    = SW'(count) + SW'(inflight) - SW'(drop);
    imem_req_valid = start & ~redirect_valid
                   & (inflight < IW'(MAX_OUT))
                   & (credit_used < SW'(DEPTH));
    imem_req_addr  = pc;
    fire           = imem_req_valid & imem_req_ready;
    out_valid      = (count != '0);
    pop            = out_valid & out_ready;
    // A response landing in the redirect cycle belongs to the old stream.
    push           = imem_rsp_valid & (drop == '0) & ~redirect_valid;
    out_instr      = out_valid ? fifo_instr[rd_ptr] : 32'h0;
    out_pc         = out_valid ? fifo_pc[rd_ptr]    : 32'h0;
  end

  // Control state: PC, outstanding/discard counters and FIFO pointers.
  always_ff @(posedge clock) begin
    if (!start) begin
      pc       <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      // fire is never set in a redirect cycle, so this holds for both paths.
      inflight <= inflight + IW'(fire) - IW'(imem_rsp_valid);
      if (redirect_valid) begin
        pc       <= redirect_pc;
        rsp_pc   <= redirect_pc;
        // Everything still outstanding after this edge is from the old path.
        drop     <= inflight - IW'(imem_rsp_valid);
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (fire) begin
          pc <= pc + 32'd4;
        end
        if (imem_rsp_valid && (drop != '0)) begin
          drop <= drop - IW'(1);
        end
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // FIFO storage: payload only, validity is tracked by count.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr]    <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clock;
  logic        start;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int vectors     = 0;
  int miscompares = 0;

  instr_fetch_unit dut (
    .clock          (clock),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory model: in-order, fixed latency mem_lat, word = A000_0000 | addr.
  int          mem_lat = 1;
  int          cyc     = 0;
  logic [31:0] qa [$];
  int          qd [$];

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
  end

  always begin
    @(posedge clock);
    if (!start) begin
      qa.delete();
      qd.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      qa.push_back(imem_req_addr);
      qd.push_back(cyc + mem_lat);
    end
    cyc = cyc + 1;
    #1;
    if (qa.size() > 0 && qd[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hA000_0000 | qa[0];
      void'(qa.pop_front());
      void'(qd.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  end

  // A response must never arrive while nothing is outstanding.
  always @(posedge clock) begin
    if (start && imem_rsp_valid && dut.inflight == '0) begin
      miscompares++;
      $display("FAIL rsp_with_no_inflight: got rsp_valid=1 with inflight=0 at t=%0t", $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at t=%0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic do_reset();
    next_cycle();
    start          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    do_reset();
    sample();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (out_instr !== 32'h0) begin miscompares++; $display("FAIL reset_out_instr: got %h expected 00000000", out_instr); end
    vectors++; if (out_pc !== 32'h0) begin miscompares++; $display("FAIL reset_out_pc: got %h expected 00000000", out_pc); end
    vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    vectors++; if (imem_req_addr !== 32'h0) begin miscompares++; $display("FAIL reset_req_addr: got %h expected 00000000", imem_req_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    mem_lat   = 1;
    out_ready = 1'b1;
    next_cycle();
    start = 1'b1;
    for (int j = 0; j < 12; j++) begin
      if (j > 0) next_cycle();
      sample();
      if (j == 0) begin
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin miscompares++; $display("FAIL stream_first_req: got valid=%b addr=%h expected 1/00000000", imem_req_valid, imem_req_addr); end
      end
      vectors++; if (out_valid !== (j >= 2)) begin miscompares++; $display("FAIL stream_out_valid c%0d: got %b expected %b", j, out_valid, (j >= 2)); end
      if (j >= 2) begin
        exp_pc = 32'(4 * (j - 2));
        vectors++; if (out_pc !== exp_pc || out_instr !== (32'hA000_0000 | exp_pc)) begin miscompares++; $display("FAIL stream_out c%0d: got pc=%h instr=%h expected pc=%h", j, out_pc, out_instr, exp_pc); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    do_reset();
    mem_lat   = 1;
    out_ready = 1'b0;
    next_cycle();
    start = 1'b1;
    for (int j = 0; j < 15; j++) begin
      if (j > 0) next_cycle();
      if (j == 10) out_ready = 1'b1;
      sample();
      if (j == 3) begin
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hC) begin miscompares++; $display("FAIL bp_last_req: got valid=%b addr=%h expected 1/0000000c", imem_req_valid, imem_req_addr); end
      end
      if (j == 4 || j == 9) begin
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL bp_req_blocked c%0d: got %b expected 0", j, imem_req_valid); end
      end
      if (j == 9) begin
        vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin miscompares++; $display("FAIL bp_head: got valid=%b pc=%h expected 1/00000000", out_valid, out_pc); end
      end
      if (j >= 10) begin
        exp_pc = 32'(4 * (j - 10));
        vectors++; if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== (32'hA000_0000 | exp_pc)) begin miscompares++; $display("FAIL bp_drain c%0d: got valid=%b pc=%h instr=%h expected pc=%h", j, out_valid, out_pc, out_instr, exp_pc); end
      end
      if (j == 11) begin
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin miscompares++; $display("FAIL bp_resume_req: got valid=%b addr=%h expected 1/00000010", imem_req_valid, imem_req_addr); end
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_redirect_outstanding();
    do_reset();
    mem_lat   = 3;
    out_ready = 1'b1;
    next_cycle();
    start = 1'b1;
    for (int j = 0; j < 10; j++) begin
      if (j > 0) next_cycle();
      redirect_valid = (j == 2);
      redirect_pc    = 32'h0000_0100;
      sample();
      if (j == 2 || j == 3) begin
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL redir_req_held c%0d: got %b expected 0", j, imem_req_valid); end
      end
      if (j == 3) begin
        vectors++; if (imem_req_addr !== 32'h100) begin miscompares++; $display("FAIL redir_pc_loaded: got %h expected 00000100", imem_req_addr); end
      end
      if (j == 4) begin
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin miscompares++; $display("FAIL redir_first_req: got valid=%b addr=%h expected 1/00000100", imem_req_valid, imem_req_addr); end
      end
      if (j <= 7) begin
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL redir_stale_hidden c%0d: got valid=%b pc=%h expected valid 0", j, out_valid, out_pc); end
      end
      if (j == 8) begin
        vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'hA000_0100) begin miscompares++; $display("FAIL redir_first_out: got valid=%b pc=%h instr=%h expected 1/00000100/a0000100", out_valid, out_pc, out_instr); end
      end
      if (j == 9) begin
        vectors++; if (out_pc !== 32'h104) begin miscompares++; $display("FAIL redir_second_out: got %h expected 00000104", out_pc); end
      end
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_redirect_collision();
    do_reset();
    mem_lat   = 2;
    out_ready = 1'b0;
    next_cycle();
    start = 1'b1;
    for (int j = 0; j < 11; j++) begin
      if (j > 0) next_cycle();
      out_ready      = (j >= 4);
      redirect_valid = (j == 5);
      redirect_pc    = 32'h0000_0202;
      sample();
      if (j == 4) begin
        vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin miscompares++; $display("FAIL coll_pre_head: got valid=%b pc=%h expected 1/00000000", out_valid, out_pc); end
      end
      if (j == 5) begin
        vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instr !== 32'hA000_0004) begin miscompares++; $display("FAIL coll_pop: got valid=%b pc=%h instr=%h expected 1/00000004/a0000004", out_valid, out_pc, out_instr); end
        vectors++; if (imem_rsp_valid !== 1'b1 || imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL coll_setup: got rsp_valid=%b req_valid=%b expected 1/0", imem_rsp_valid, imem_req_valid); end
      end
      if (j == 6) begin
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h202) begin miscompares++; $display("FAIL coll_first_req: got valid=%b addr=%h expected 1/00000202", imem_req_valid, imem_req_addr); end
      end
      if (j == 7) begin
        vectors++; if (imem_req_addr !== 32'h206) begin miscompares++; $display("FAIL coll_second_req: got %h expected 00000206", imem_req_addr); end
      end
      if (j >= 6 && j <= 8) begin
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL coll_flushed c%0d: got valid=%b pc=%h expected valid 0", j, out_valid, out_pc); end
      end
      if (j == 9) begin
        vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h202 || out_instr !== 32'hA000_0202) begin miscompares++; $display("FAIL coll_first_out: got valid=%b pc=%h instr=%h expected 1/00000202/a0000202", out_valid, out_pc, out_instr); end
      end
      if (j == 10) begin
        vectors++; if (out_pc !== 32'h206) begin miscompares++; $display("FAIL coll_second_out: got %h expected 00000206", out_pc); end
      end
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_req_stall();
    do_reset();
    mem_lat   = 1;
    out_ready = 1'b1;
    next_cycle();
    start = 1'b1;
    for (int j = 0; j < 10; j++) begin
      if (j > 0) next_cycle();
      imem_req_ready = !(j >= 2 && j <= 6);
      sample();
      if (j >= 2 && j <= 7) begin
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin miscompares++; $display("FAIL stall_hold c%0d: got valid=%b addr=%h expected 1/00000008", j, imem_req_valid, imem_req_addr); end
      end
      if (j == 4) begin
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_dry: got %b expected 0", out_valid); end
      end
      if (j == 8) begin
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hC) begin miscompares++; $display("FAIL stall_advance: got valid=%b addr=%h expected 1/0000000c", imem_req_valid, imem_req_addr); end
      end
      if (j == 9) begin
        vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h8) begin miscompares++; $display("FAIL stall_out: got valid=%b pc=%h expected 1/00000008", out_valid, out_pc); end
      end
    end
    imem_req_ready = 1'b1;
  endtask

  task automatic test_midstream_reset();
    do_reset();
    mem_lat   = 1;
    out_ready = 1'b0;
    next_cycle();
    start = 1'b1;
    for (int j = 0; j < 14; j++) begin
      if (j > 0) next_cycle();
      if (j == 8) start = 1'b0;
      if (j == 10) begin start = 1'b1; out_ready = 1'b1; end
      sample();
      if (j == 7) begin
        vectors++; if (out_valid !== 1'b1 || imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL mrst_full: got out_valid=%b req_valid=%b expected 1/0", out_valid, imem_req_valid); end
      end
      if (j == 9) begin
        vectors++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin miscompares++; $display("FAIL mrst_cleared: got out_valid=%b req_valid=%b addr=%h expected 0/0/00000000", out_valid, imem_req_valid, imem_req_addr); end
        vectors++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin miscompares++; $display("FAIL mrst_outputs: got pc=%h instr=%h expected 0/0", out_pc, out_instr); end
      end
      if (j == 10) begin
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin miscompares++; $display("FAIL mrst_resume_req: got valid=%b addr=%h expected 1/00000000", imem_req_valid, imem_req_addr); end
      end
      if (j == 11) begin
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mrst_no_stale: got valid=%b pc=%h expected valid 0", out_valid, out_pc); end
      end
      if (j == 12) begin
        vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'hA000_0000) begin miscompares++; $display("FAIL mrst_first_out: got valid=%b pc=%h instr=%h expected 1/00000000/a0000000", out_valid, out_pc, out_instr); end
      end
      if (j == 13) begin
        vectors++; if (out_pc !== 32'h4) begin miscompares++; $display("FAIL mrst_second_out: got %h expected 00000004", out_pc); end
      end
    end
  endtask

  initial begin
    start          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_collision();
    test_req_stall();
    test_midstream_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end fetch stage directly upstream of the pipelined CPU core; sole source of the core's instruction input.
- Holds the fetch PC and issues in-order requests to instruction memory over a ready/valid request channel.
- Memory latency is variable. Responses are buffered in a small FIFO and handed to decode over a valid/ready handshake.
- Branch/jump redirects flush buffered instructions and discard responses still in flight.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
DEPTH, 4, instruction FIFO entries (power of 2, >=2)
MAX_OUT, 2, maximum outstanding imem requests (1..DEPTH)

Ports:
clock  in  1  system clock, rising-edge
start  in  1  synchronous active-low reset: 0 = reset, 1 = run
redirect_valid  in  1  core requests PC change (taken branch/jump)
redirect_pc  in  32  new fetch byte address
imem_req_valid  out  1  request to instruction memory
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  byte address of request
imem_rsp_valid  in  1  response beat, in request order
imem_rsp_data  in  32  instruction word
out_valid  out  1  instruction available to decode
out_ready  in  1  decode accepts instruction
out_instr  out  32  instruction word (to core i_datain)
out_pc  out  32  byte address of out_instr

Behaviour:
- Reset: when start=0 at a clock edge, set pc=RESET_PC, inflight=0, drop=0, FIFO empty. Outputs after reset: imem_req_valid=0 for that cycle, out_valid=0, out_instr=0, out_pc=0, imem_req_addr=RESET_PC. Reset mid-operation abandons all state. Responses arriving after reset deassertion that belong to pre-reset requests are not tracked; the memory is reset together with this block.
- Request issue:
  - imem_req_valid = start & ~redirect_valid & (inflight < MAX_OUT) & (count + inflight - drop < DEPTH).
  - imem_req_addr = pc.
  - On req fire (valid & ready): pc += 4 (wraps mod 2^32), inflight += 1.
  - Once asserted, valid is held with a stable address until ready, unless a redirect occurs.
- Response:
  - Every imem_rsp_valid decrements inflight.
  - If drop > 0, the word is discarded and drop -= 1.
  - Otherwise {rsp_pc, data} is pushed to the FIFO. rsp_pc is taken from an internal response-PC counter that increments by 4 per kept response.
  - A response never arrives with inflight=0; this is a bench assertion.
- Output:
  - out_valid = FIFO non-empty; out_instr/out_pc = head entry.
  - Pop on out_valid & out_ready.
  - Latency: response at edge N is visible on out_* at edge N+1 (registered FIFO, no bypass).
  - Simultaneous push and pop is allowed at any occupancy, including full.
- Redirect (redirect_valid=1 at an edge):
  - pc = redirect_pc; response-PC counter = redirect_pc.
  - FIFO cleared. A handshake in the same cycle still counts as consumed.
  - drop = inflight - (imem_rsp_valid ? 1 : 0), i.e. every request still outstanding after this edge will be discarded. A response arriving in the redirect cycle is itself discarded.
  - No request is issued in the redirect cycle. Fetch at redirect_pc starts the next cycle.
  - Back-to-back redirects: the last one wins; drop is recomputed each time.
- Invariants:
  - count + inflight - drop <= DEPTH.
  - drop <= inflight <= MAX_OUT.
  - FIFO never overflows. Because of the credit rule, no backpressure on responses is needed.
- Redirect address alignment is not checked; low 2 bits pass through unchanged.

Test Plan:
1. Reset then stream (memory returns addr-based word 32'hA000_0000|addr, 1-cycle latency, out_ready=1) -> out_pc 0,4,8,12… in order; first out_valid 3 cycles after start rises; one instruction per cycle sustained.
2. Backpressure (out_ready=0 for 10 cycles) -> exactly DEPTH=4 entries buffered (pc 0..12); imem_req_valid drops to 0; releasing out_ready delivers 0,4,8,12,16 with no loss or duplicate.
3. Redirect with 2 outstanding requests (3-cycle latency), redirect_pc=32'h0000_0100 -> both stale responses discarded; FIFO flushed; next out_pc=32'h100, out_instr=32'hA000_0100.
4. Redirect coinciding with a response and an out handshake -> response discarded; popped instruction counts once; drop equals remaining inflight; first delivered out_pc=redirect_pc.
5. imem_req_ready held 0 for 5 cycles -> imem_req_valid stays 1 with addr constant (e.g. 32'h8); pc advances only on acceptance.
6. start pulled to 0 mid-stream with FIFO full -> next cycle out_valid=0, imem_req_valid=0, imem_req_addr=RESET_PC; after start=1, fetch resumes at 0.
